// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, 8x oversampling, 3-sample majority vote per bit
// Delivers each byte as a one-cycle strobe and flags stop-bit framing errors.
module uart_receiver #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_busy
);

    localparam int Div  = (ClkFrequency + Baud * 4) / (Baud * 8);
    localparam int CntW = (Div > 2) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(Div - 1);

    generate
        if (Div < 2) begin : g_div_check
            $error("uart_receiver: clocks per oversample tick must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic            rx_meta_q;
    logic            rx_s_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            tick;
    state_t          state_q;
    logic [2:0]      phase_q;
    logic [2:0]      bitidx_q;
    logic [7:0]      shreg_q;
    logic            smp3_q;
    logic            smp4_q;
    logic            vote;
    logic [7:0]      data_q;
    logic            ready_q;
    logic            frame_err_q;
    logic            busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick  = (cnt_q == DivMax);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Third sample is the live synchronized line on the phase-5 tick.
    assign vote = (smp3_q & smp4_q) | (smp3_q & rx_s_q) | (smp4_q & rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            bitidx_q    <= 3'd0;
            shreg_q     <= 8'h00;
            smp3_q      <= 1'b1;
            smp4_q      <= 1'b1;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                if (phase_q == 3'd3) smp3_q <= rx_s_q;
                if (phase_q == 3'd4) smp4_q <= rx_s_q;
                case (state_q)
                    IDLE: begin
                        if (!rx_s_q) begin
                            state_q <= START;
                            phase_q <= 3'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        phase_q <= phase_q + 3'd1;
                        if (phase_q == 3'd5 && vote) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (phase_q == 3'd7) begin
                            state_q  <= DATA;
                            phase_q  <= 3'd0;
                            bitidx_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        phase_q <= phase_q + 3'd1;
                        if (phase_q == 3'd5) shreg_q <= {vote, shreg_q[7:1]};
                        if (phase_q == 3'd7) begin
                            if (bitidx_q == 3'd7) begin
                                state_q <= STOP;
                                phase_q <= 3'd0;
                            end else begin
                                bitidx_q <= bitidx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        phase_q <= phase_q + 3'd1;
                        // Leaving at mid stop bit lets an early next start bit resync.
                        if (phase_q == 3'd5) begin
                            if (vote) begin
                                data_q  <= shreg_q;
                                ready_q <= 1'b1;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign RxD_frame_err  = frame_err_q;
    assign RxD_busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed bench for uart_receiver at 12 MHz / 115200 baud
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_err;
    logic       rx_busy;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         n_rdy  = 0;
    int         n_err  = 0;
    int         n_both = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] rxq[$];

    uart_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .RxD           (rxd),
        .RxD_data      (rx_data),
        .RxD_data_ready(rx_ready),
        .RxD_frame_err (rx_err),
        .RxD_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ready) begin
            rxq.push_back(rx_data);
            n_rdy++;
        end
        if (rx_err) n_err++;
        if (rx_ready && rx_err) n_both++;
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bt, input logic stop_v);
        rxd = 1'b0;
        repeat (bt) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bt) @(posedge clk);
        end
        rxd = stop_v;
        repeat (bt) @(posedge clk);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] exp);
        chk({tag, "_cnt"}, rxq.size(), 1);
        chk({tag, "_data"}, rx_data, exp);
        if (rxq.size() > 0) chk({tag, "_strobe_data"}, rxq[0], exp);
    endtask

    initial begin
        int err_base;
        logic [7:0] got;

        rst = 1'b0;
        rxd = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ready", rx_ready, 1'b0);
        chk("rst_err", rx_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        @(posedge clk);
        rst = 1'b0;

        // single frame
        idle(104);
        rxq.delete();
        err_base = n_err;
        send_byte(8'h61, 104, 1'b1);
        idle(30);
        expect_one("single", 8'h61);
        chk("single_err", n_err - err_base, 0);

        // continuous stream, no gaps
        rxq.delete();
        err_base = n_err;
        for (int i = 0; i < 33; i++) send_byte(8'(8'h61 + i), 104, 1'b1);
        idle(30);
        chk("stream_cnt", rxq.size(), 33);
        for (int i = 0; i < 33; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk($sformatf("stream_byte%0d", i), got, 8'(8'h61 + i));
        end
        chk("stream_err", n_err - err_base, 0);

        // glitch rejection
        idle(104);
        rxq.delete();
        busy_seen = 1'b0;
        rxd = 1'b0;
        repeat (26) @(posedge clk);
        idle(200);
        @(negedge clk);
        chk("glitch_busy_seen", busy_seen, 1'b1);
        chk("glitch_busy_low", rx_busy, 1'b0);
        chk("glitch_no_strobe", rxq.size(), 0);
        send_byte(8'hA5, 104, 1'b1);
        idle(30);
        expect_one("after_glitch", 8'hA5);

        // framing error, line held low
        rxq.delete();
        err_base = n_err;
        send_byte(8'h3C, 104, 1'b0);
        rxd = 1'b0;
        repeat (19 * 104) @(posedge clk);
        chk("ferr_count", n_err - err_base, 1);
        chk("ferr_no_strobe", rxq.size(), 0);
        chk("ferr_data_kept", rx_data, 8'hA5);
        chk("ferr_busy_held", rx_busy, 1'b1);
        idle(208);
        send_byte(8'h55, 104, 1'b1);
        idle(30);
        expect_one("after_ferr", 8'h55);
        chk("ferr_count_final", n_err - err_base, 1);

        // reset during data bit 4
        idle(104);
        rxq.delete();
        err_base = n_err;
        fork
            send_byte(8'hF0, 104, 1'b1);
            begin
                repeat (5 * 104 + 50) @(posedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_data", rx_data, 8'h00);
                chk("mid_rst_ready", rx_ready, 1'b0);
                chk("mid_rst_err", rx_err, 1'b0);
                chk("mid_rst_busy", rx_busy, 1'b0);
                repeat (3) @(posedge clk);
                rst = 1'b0;
            end
        join
        idle(104);
        chk("broken_no_strobe", rxq.size(), 0);
        chk("broken_no_err", n_err - err_base, 0);
        send_byte(8'h0F, 104, 1'b1);
        idle(30);
        expect_one("after_rst", 8'h0F);

        // baud skew
        rxq.delete();
        err_base = n_err;
        send_byte(8'h96, 101, 1'b1);
        idle(60);
        expect_one("skew_fast", 8'h96);
        rxq.delete();
        send_byte(8'h96, 107, 1'b1);
        idle(60);
        expect_one("skew_slow", 8'h96);
        chk("skew_err", n_err - err_base, 0);

        chk("no_dual_strobe", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
